// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake position generator and its segment buffer.
package snake_pkg;

  localparam int COORD_W = 20;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE,
    ST_DEAD
  } state_t;

  // Opposite directions share the axis bit and differ only in the sign bit.
  function automatic logic isReverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_seg_buffer.sv
// Body-segment history: a shift register of (x,y) pairs fed from the old head,
// with a combinational indexed read port for the body scan.
module snake_seg_buffer
  import snake_pkg::*;
#(
  parameter int                 DEPTH   = 15,
  parameter int                 IDX_W   = 4,
  parameter logic [COORD_W-1:0] STEP    = 20'd16,
  parameter logic [COORD_W-1:0] START_X = 20'd400,
  parameter logic [COORD_W-1:0] START_Y = 20'd240
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               shiftEn,
  input  logic [COORD_W-1:0] inX,
  input  logic [COORD_W-1:0] inY,
  input  logic [IDX_W-1:0]   rdIdx,
  output logic [COORD_W-1:0] rdX,
  output logic [COORD_W-1:0] rdY
);

  logic [COORD_W-1:0] segX [DEPTH];
  logic [COORD_W-1:0] segY [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_seg
    localparam logic [COORD_W-1:0] RST_X = START_X - COORD_W'(k + 1) * STEP;

    // NOTE: this storage is reset (unlike a plain RAM) because the initial snake
    // body is a defined horizontal line that is scanned on the very first move.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        segX[k] <= RST_X;
        segY[k] <= START_Y;
      end else if (shiftEn) begin
        if (k == 0) begin
          segX[k] <= inX;
          segY[k] <= inY;
        end else begin
          segX[k] <= segX[k-1];
          segY[k] <= segY[k-1];
        end
      end
    end
  end

  assign rdX = segX[rdIdx];
  assign rdY = segY[rdIdx];

endmodule

// File: rtl/snake_position_gen.sv
// Snake head/length owner: moves the head on each tick, shifts the body history,
// then streams the body one segment per cycle to the collision detector.
module snake_position_gen
  import snake_pkg::*;
#(
  parameter int                 MAX_LEN   = 16,
  parameter int                 START_LEN = 3,
  parameter logic [COORD_W-1:0] STEP      = 20'd16,
  parameter logic [COORD_W-1:0] START_X   = 20'd400,
  parameter logic [COORD_W-1:0] START_Y   = 20'd240
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               move_tick,
  input  logic [1:0]         dir,
  input  logic               grow,
  input  logic               game_over,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [COORD_W-1:0] body_x,
  output logic [COORD_W-1:0] body_y,
  output logic               body_valid,
  output logic               scan_done,
  output logic [5:0]         length,
  output logic               alive
);

  localparam int         SEG_DEPTH = MAX_LEN - 1;
  localparam int         SEG_IDX_W = (SEG_DEPTH > 1) ? $clog2(SEG_DEPTH) : 1;
  localparam logic [5:0] MAX_LEN_V = 6'(MAX_LEN);
  localparam logic [5:0] START_LEN_V = 6'(START_LEN);

  state_t             state, stateNext;
  logic [5:0]         idx, idxNext;
  logic               doMove;
  dir_t               curDir, effDir;
  logic               pendingMove, growPending;
  logic [5:0]         lenReg;
  logic [COORD_W-1:0] headX, headY, nextHeadX, nextHeadY;
  logic [COORD_W-1:0] segRdX, segRdY;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    doMove    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (move_tick || pendingMove) begin
          doMove    = 1'b1;
          stateNext = ST_SCAN;
          idxNext   = '0;
        end
      end
      ST_SCAN: begin
        if (game_over) begin
          stateNext = ST_DEAD;
        end else if (idx == lenReg - 6'd2) begin
          stateNext = ST_DONE;
        end else begin
          idxNext = idx + 6'd1;
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      ST_DEAD: stateNext = ST_DEAD;
      default: stateNext = ST_IDLE;
    endcase
  end

  assign effDir = isReverse(dir, curDir) ? curDir : dir_t'(dir);

  always_comb begin
    nextHeadX = headX;
    nextHeadY = headY;
    case (effDir)
      DIR_UP:    nextHeadY = headY - STEP;
      DIR_DOWN:  nextHeadY = headY + STEP;
      DIR_LEFT:  nextHeadX = headX - STEP;
      DIR_RIGHT: nextHeadX = headX + STEP;
      default:   nextHeadX = headX;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      headX       <= START_X;
      headY       <= START_Y;
      curDir      <= DIR_RIGHT;
      lenReg      <= START_LEN_V;
      pendingMove <= 1'b0;
      growPending <= 1'b0;
    end else if (doMove) begin
      headX       <= nextHeadX;
      headY       <= nextHeadY;
      curDir      <= effDir;
      pendingMove <= 1'b0;
      // A grow arriving with this move is held for the following one.
      growPending <= grow;
      if (growPending && (lenReg < MAX_LEN_V)) begin
        lenReg <= lenReg + 6'd1;
      end
    end else if (state != ST_DEAD) begin
      growPending <= growPending | grow;
      if (state != ST_IDLE && move_tick) begin
        pendingMove <= 1'b1;
      end
    end
  end

  snake_seg_buffer #(
    .DEPTH  (SEG_DEPTH),
    .IDX_W  (SEG_IDX_W),
    .STEP   (STEP),
    .START_X(START_X),
    .START_Y(START_Y)
  ) u_seg_buffer (
    .clk    (clk),
    .resetn (resetn),
    .shiftEn(doMove),
    .inX    (headX),
    .inY    (headY),
    .rdIdx  (idx[SEG_IDX_W-1:0]),
    .rdX    (segRdX),
    .rdY    (segRdY)
  );

  assign head_x     = headX;
  assign head_y     = headY;
  assign body_valid = (state == ST_SCAN);
  assign body_x     = body_valid ? segRdX : '0;
  assign body_y     = body_valid ? segRdY : '0;
  assign scan_done  = (state == ST_DONE);
  assign length     = lenReg;
  assign alive      = (state != ST_DEAD);

endmodule

// File: tb/tb_snake_position_gen.sv
// Scoreboard bench: a behavioural snake model queues expected body segments
// per move; a negedge monitor pops and compares each presented segment.
module tb_snake_position_gen;
  import snake_pkg::*;

  localparam int          MAX_LEN = 16;
  localparam logic [19:0] STEP    = 20'd16;
  localparam logic [19:0] SX      = 20'd400;
  localparam logic [19:0] SY      = 20'd240;

  logic        clk = 1'b0;
  logic        resetn, move_tick, grow, game_over;
  logic [1:0]  dir;
  logic [19:0] head_x, head_y, body_x, body_y;
  logic        body_valid, scan_done, alive;
  logic [5:0]  length;

  snake_position_gen dut (
    .clk(clk), .resetn(resetn), .move_tick(move_tick), .dir(dir), .grow(grow),
    .game_over(game_over), .head_x(head_x), .head_y(head_y), .body_x(body_x),
    .body_y(body_y), .body_valid(body_valid), .scan_done(scan_done),
    .length(length), .alive(alive)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] x;
    logic [19:0] y;
  } pos_t;

  pos_t        expQ[$];
  int          checks = 0;
  int          errors = 0;

  logic [19:0] mHx, mHy;
  logic [19:0] mSx[MAX_LEN-1];
  logic [19:0] mSy[MAX_LEN-1];
  int          mLen;
  logic [1:0]  mDir;
  bit          mGrowPend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    pos_t e;
    if (resetn && body_valid) begin
      if (expQ.size() == 0) begin
        check("bodyUnexpected", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        check("bodyX", 32'(body_x), 32'(e.x));
        check("bodyY", 32'(body_y), 32'(e.y));
      end
    end
  end

  task automatic modelReset();
    mHx = SX; mHy = SY; mLen = 3; mDir = 2'b11; mGrowPend = 1'b0;
    for (int k = 0; k < MAX_LEN - 1; k++) begin
      mSx[k] = SX - 20'(k + 1) * STEP;
      mSy[k] = SY;
    end
    expQ.delete();
  endtask

  task automatic modelMove(input logic [1:0] d);
    logic [1:0] eff;
    eff = ((d[1] == mDir[1]) && (d[0] != mDir[0])) ? mDir : d;
    for (int k = MAX_LEN - 2; k > 0; k--) begin
      mSx[k] = mSx[k-1];
      mSy[k] = mSy[k-1];
    end
    mSx[0] = mHx; mSy[0] = mHy;
    case (eff)
      2'b00: mHy = mHy - STEP;
      2'b01: mHy = mHy + STEP;
      2'b10: mHx = mHx - STEP;
      default: mHx = mHx + STEP;
    endcase
    mDir = eff;
    if (mGrowPend && mLen < MAX_LEN) mLen++;
    mGrowPend = 1'b0;
    for (int k = 0; k < mLen - 1; k++) expQ.push_back({mSx[k], mSy[k]});
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (scan_done) break;
      if (cyc > 100) begin
        check("scanTimeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic checkHead(input string tag);
    check({tag, "X"}, 32'(head_x), 32'(mHx));
    check({tag, "Y"}, 32'(head_y), 32'(mHy));
    check({tag, "Len"}, 32'(length), 32'(mLen));
  endtask

  task automatic doMove(input logic [1:0] d, input logic g);
    int cyc;
    @(negedge clk);
    move_tick = 1'b1; dir = d; grow = g;
    modelMove(d);
    if (g) mGrowPend = 1'b1;
    @(negedge clk);
    move_tick = 1'b0; grow = 1'b0;
    checkHead("head");
    check("validFirst", 32'(body_valid), 32'd1);
    waitDone(cyc);
    check("scanLen", 32'(cyc), 32'(mLen - 1));
    check("queueDrained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic pulseGrow();
    @(negedge clk); grow = 1'b1; mGrowPend = 1'b1;
    @(negedge clk); grow = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetn = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int cyc;
    int doneCount;
    resetn = 1'b0; move_tick = 1'b0; grow = 1'b0; game_over = 1'b0; dir = 2'b11;
    modelReset();
    repeat (3) @(negedge clk);
    checkHead("rst");
    check("rstAlive", 32'(alive), 32'd1);
    check("rstValid", 32'(body_valid), 32'd0);
    check("rstDone", 32'(scan_done), 32'd0);
    check("rstBodyX", 32'(body_x), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    doMove(2'b11, 1'b0);   // right: head (416,240), body from reset shape
    doMove(2'b10, 1'b0);   // reversal ignored
    pulseGrow();
    doMove(2'b11, 1'b0);   // grows to 4, tail shows old tail
    doMove(2'b00, 1'b1);   // grow in same cycle as move: no growth yet
    doMove(2'b01, 1'b0);   // down is reverse of up: keeps moving up, grows to 5

    // game_over outside a scan is ignored
    @(negedge clk); game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    check("idleGameOverAlive", 32'(alive), 32'd1);
    doMove(2'b10, 1'b0);

    // two ticks during a scan produce exactly one extra move
    @(negedge clk); move_tick = 1'b1; dir = 2'b11;
    modelMove(2'b11);
    @(negedge clk);
    checkHead("pendHead");
    repeat (2) @(negedge clk);
    move_tick = 1'b0;
    modelMove(2'b11);
    waitDone(cyc);
    waitDone(cyc);
    checkHead("pendHead2");
    repeat (10) @(negedge clk);
    check("pendQueue", 32'(expQ.size()), 32'd0);

    // saturate length, moving up until Y reaches 0
    for (int i = 0; i < 13; i++) begin
      pulseGrow();
      doMove(2'b00, 1'b0);
    end
    check("satLen", 32'(length), 32'd16);
    doMove(2'b00, 1'b0);   // Y wraps below zero

    // collision on the second scan cycle
    @(negedge clk); move_tick = 1'b1; dir = 2'b00;
    modelMove(2'b00);
    @(negedge clk); move_tick = 1'b0;
    checkHead("deathHead");
    @(negedge clk); game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    check("deadAlive", 32'(alive), 32'd0);
    check("deadValid", 32'(body_valid), 32'd0);
    check("deadDone", 32'(scan_done), 32'd0);
    check("abortQueue", 32'(expQ.size()), 32'(mLen - 3));
    expQ.delete();
    doneCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); move_tick = 1'b1; grow = 1'b1; dir = 2'b10;
      if (scan_done) doneCount++;
      @(negedge clk); move_tick = 1'b0; grow = 1'b0;
      if (scan_done) doneCount++;
    end
    repeat (3) @(negedge clk);
    checkHead("frozen");
    check("frozenAlive", 32'(alive), 32'd0);
    check("frozenDone", 32'(doneCount), 32'd0);

    // reset mid-scan restores everything
    applyReset();
    @(negedge clk); move_tick = 1'b1; dir = 2'b01;
    @(negedge clk); move_tick = 1'b0;
    resetn = 1'b0;
    modelReset();
    #1;
    check("midRstValid", 32'(body_valid), 32'd0);
    checkHead("midRst");
    check("midRstAlive", 32'(alive), 32'd1);
    @(negedge clk); resetn = 1'b1;
    doMove(2'b11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
